// File: rtl/bomb_pkg.sv
// Shared types and blast geometry for the bomb arena controller.
package bomb_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_ARMED = 2'd1,
    SLOT_BOOM  = 2'd2
  } slot_state_e;

  typedef enum logic {
    ROUND_PLAY = 1'b0,
    ROUND_OVER = 1'b1
  } round_state_e;

  localparam int DEFAULT_GRID_W = 39;
  localparam int DEFAULT_GRID_H = 29;

  // Arms only extend along odd rows/columns because walls sit on even/even tiles;
  // targets outside the grid are never covered, which also clips the arms.
  function automatic logic in_blast(input int bx, input int by, input int tx, input int ty,
                                    input int armLen, input int gridW, input int gridH);
    logic hit;
    hit = 1'b0;
    if (tx >= 0 && tx < gridW && ty >= 0 && ty < gridH) begin
      if (tx == bx && ty == by) hit = 1'b1;
      if (ty == by && by[0] && tx >= bx - armLen && tx <= bx + armLen) hit = 1'b1;
      if (tx == bx && bx[0] && ty >= by - armLen && ty <= by + armLen) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/bomb_arena_ctrl_if.sv
// Player-side, renderer-side and round-status signals of the bomb arena controller.
interface bomb_arena_ctrl_if #(
  parameter int N_PLAYERS        = 2,
  parameter int BOMBS_PER_PLAYER = 3,
  parameter int COORD_W          = 6
);
  localparam int NS = N_PLAYERS * BOMBS_PER_PLAYER;

  logic                         tick;
  logic                         restart;
  logic [N_PLAYERS-1:0]         drop;
  logic [N_PLAYERS*COORD_W-1:0] pl_x;
  logic [N_PLAYERS*COORD_W-1:0] pl_y;
  logic [NS-1:0]                slot_valid;
  logic [NS-1:0]                slot_boom;
  logic [NS*COORD_W-1:0]        slot_x;
  logic [NS*COORD_W-1:0]        slot_y;
  logic [COORD_W-1:0]           qx;
  logic [COORD_W-1:0]           qy;
  logic                         q_bomb;
  logic                         q_blast;
  logic [N_PLAYERS-1:0]         alive;
  logic                         game_over;
  logic [1:0]                   winner;
  logic                         draw;

  modport master (
    output tick, restart, drop, pl_x, pl_y, qx, qy,
    input  slot_valid, slot_boom, slot_x, slot_y, q_bomb, q_blast,
           alive, game_over, winner, draw
  );

  modport slave (
    input  tick, restart, drop, pl_x, pl_y, qx, qy,
    output slot_valid, slot_boom, slot_x, slot_y, q_bomb, q_blast,
           alive, game_over, winner, draw
  );
endinterface

// File: rtl/bomb_slot.sv
// One bomb slot: position, lifecycle state and a shared fuse/blast down-counter.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int COORD_W     = 6,
  parameter int FUSE_TICKS  = 120,
  parameter int BLAST_TICKS = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               alloc_i,
  input  logic [COORD_W-1:0] alloc_x_i,
  input  logic [COORD_W-1:0] alloc_y_i,
  input  logic               ignite_i,
  input  logic               tick_i,
  output slot_state_e        state_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o
);

  localparam int CNT_MAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FUSE_INIT  = CNT_W'(FUSE_TICKS);
  localparam logic [CNT_W-1:0] BLAST_INIT = CNT_W'(BLAST_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  slot_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  // Allocation only happens on a free slot, so it never collides with tick handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    if (clear_i) begin
      state_d = SLOT_FREE;
      cnt_d   = '0;
      x_d     = '0;
      y_d     = '0;
    end else if (alloc_i && state_q == SLOT_FREE) begin
      state_d = SLOT_ARMED;
      cnt_d   = FUSE_INIT;
      x_d     = alloc_x_i;
      y_d     = alloc_y_i;
    end else if (tick_i) begin
      case (state_q)
        SLOT_ARMED: begin
          if (ignite_i || cnt_q == CNT_ONE) begin
            state_d = SLOT_BOOM;
            cnt_d   = BLAST_INIT;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        SLOT_BOOM: begin
          if (cnt_q == CNT_ONE) begin
            state_d = SLOT_FREE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_FREE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign state_o = state_q;
  assign x_o     = x_q;
  assign y_o     = y_q;

endmodule

// File: rtl/bomb_arena_ctrl.sv
// Bomb pool, chain detonation, player survival and PLAY/OVER round control for the tile arena.
module bomb_arena_ctrl
  import bomb_pkg::*;
#(
  parameter int N_PLAYERS        = 2,
  parameter int BOMBS_PER_PLAYER = 3,
  parameter int COORD_W          = 6,
  parameter int FUSE_TICKS       = 120,
  parameter int BLAST_TICKS      = 30,
  parameter int BLAST_RANGE      = 2,
  parameter int GRID_W           = DEFAULT_GRID_W,
  parameter int GRID_H           = DEFAULT_GRID_H
) (
  input logic clk,
  input logic reset,
  bomb_arena_ctrl_if.slave bus
);

  localparam int NS = N_PLAYERS * BOMBS_PER_PLAYER;

  slot_state_e          slotState [NS];
  logic [COORD_W-1:0]   slotX [NS];
  logic [COORD_W-1:0]   slotY [NS];
  logic [NS-1:0]        slotAlloc, slotIgnite;
  logic [NS-1:0]        slotValidVec, slotBoomVec;
  logic [NS*COORD_W-1:0] slotXVec, slotYVec;
  logic [N_PLAYERS-1:0] grant, playerHit, aliveNext;
  logic [COORD_W-1:0]   px, py;
  logic                 tileBusy, found;
  logic [BOMBS_PER_PLAYER-1:0] freeSel;
  logic [1:0]           winnerIdx;
  logic                 qBomb_d, qBlast_d;
  logic                 tickEn, allocEn;

  round_state_e         roundState_q;
  logic [N_PLAYERS-1:0] alive_q;
  logic                 gameOver_q, draw_q, qBomb_q, qBlast_q;
  logic [1:0]           winner_q;

  assign allocEn = (roundState_q == ROUND_PLAY) && !bus.restart;
  assign tickEn  = allocEn && bus.tick;

  for (genvar s = 0; s < NS; s++) begin : gSlot
    localparam int OWNER = s / BOMBS_PER_PLAYER;
    bomb_slot #(
      .COORD_W    (COORD_W),
      .FUSE_TICKS (FUSE_TICKS),
      .BLAST_TICKS(BLAST_TICKS)
    ) uSlot (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (bus.restart),
      .alloc_i  (slotAlloc[s]),
      .alloc_x_i(bus.pl_x[OWNER*COORD_W +: COORD_W]),
      .alloc_y_i(bus.pl_y[OWNER*COORD_W +: COORD_W]),
      .ignite_i (slotIgnite[s]),
      .tick_i   (tickEn),
      .state_o  (slotState[s]),
      .x_o      (slotX[s]),
      .y_o      (slotY[s])
    );
  end

  // Players are granted in index order so a lower-index drop claims a shared tile first.
  always_comb begin
    grant     = '0;
    slotAlloc = '0;
    px        = '0;
    py        = '0;
    tileBusy  = 1'b0;
    found     = 1'b0;
    freeSel   = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      px       = bus.pl_x[p*COORD_W +: COORD_W];
      py       = bus.pl_y[p*COORD_W +: COORD_W];
      tileBusy = 1'b0;
      for (int s = 0; s < NS; s++)
        if (slotState[s] != SLOT_FREE && slotX[s] == px && slotY[s] == py) tileBusy = 1'b1;
      for (int q = 0; q < N_PLAYERS; q++)
        if (q < p && grant[q] && bus.pl_x[q*COORD_W +: COORD_W] == px &&
            bus.pl_y[q*COORD_W +: COORD_W] == py) tileBusy = 1'b1;
      found   = 1'b0;
      freeSel = '0;
      for (int b = 0; b < BOMBS_PER_PLAYER; b++)
        if (!found && slotState[p*BOMBS_PER_PLAYER + b] == SLOT_FREE) begin
          freeSel[b] = 1'b1;
          found      = 1'b1;
        end
      if (allocEn && bus.drop[p] && found && !tileBusy) begin
        grant[p] = 1'b1;
        for (int b = 0; b < BOMBS_PER_PLAYER; b++)
          slotAlloc[p*BOMBS_PER_PLAYER + b] = freeSel[b];
      end
    end
  end

  // Every consumer of blast coverage looks at the pre-tick state, so chains advance one hop per tick.
  always_comb begin
    slotIgnite = '0;
    playerHit  = '0;
    qBlast_d   = 1'b0;
    qBomb_d    = 1'b0;
    for (int t = 0; t < NS; t++) begin
      if (slotState[t] == SLOT_BOOM) begin
        for (int s = 0; s < NS; s++)
          if (in_blast(int'(slotX[t]), int'(slotY[t]), int'(slotX[s]), int'(slotY[s]),
                       BLAST_RANGE, GRID_W, GRID_H)) slotIgnite[s] = 1'b1;
        for (int p = 0; p < N_PLAYERS; p++)
          if (in_blast(int'(slotX[t]), int'(slotY[t]),
                       int'(bus.pl_x[p*COORD_W +: COORD_W]), int'(bus.pl_y[p*COORD_W +: COORD_W]),
                       BLAST_RANGE, GRID_W, GRID_H)) playerHit[p] = 1'b1;
        if (in_blast(int'(slotX[t]), int'(slotY[t]), int'(bus.qx), int'(bus.qy),
                     BLAST_RANGE, GRID_W, GRID_H)) qBlast_d = 1'b1;
      end
      if (slotState[t] == SLOT_ARMED && slotX[t] == bus.qx && slotY[t] == bus.qy &&
          int'(bus.qx) < GRID_W && int'(bus.qy) < GRID_H) qBomb_d = 1'b1;
    end
  end

  always_comb begin
    aliveNext = alive_q & ~playerHit;
    winnerIdx = '0;
    for (int p = 0; p < N_PLAYERS; p++)
      if (aliveNext[p]) winnerIdx = 2'(p);
  end

  // Round FSM; the result outputs are latched on the tick that leaves at most one survivor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      roundState_q <= ROUND_PLAY;
      alive_q      <= '1;
      gameOver_q   <= 1'b0;
      winner_q     <= '0;
      draw_q       <= 1'b0;
    end else if (bus.restart) begin
      roundState_q <= ROUND_PLAY;
      alive_q      <= '1;
      gameOver_q   <= 1'b0;
      winner_q     <= '0;
      draw_q       <= 1'b0;
    end else if (roundState_q == ROUND_PLAY && bus.tick) begin
      alive_q <= aliveNext;
      if ($countones(aliveNext) <= 1) begin
        roundState_q <= ROUND_OVER;
        gameOver_q   <= 1'b1;
        draw_q       <= (aliveNext == '0);
        winner_q     <= winnerIdx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qBomb_q  <= 1'b0;
      qBlast_q <= 1'b0;
    end else begin
      qBomb_q  <= qBomb_d;
      qBlast_q <= qBlast_d;
    end
  end

  always_comb begin
    slotValidVec = '0;
    slotBoomVec  = '0;
    slotXVec     = '0;
    slotYVec     = '0;
    for (int s = 0; s < NS; s++) begin
      slotValidVec[s] = (slotState[s] != SLOT_FREE);
      slotBoomVec[s]  = (slotState[s] == SLOT_BOOM);
      slotXVec[s*COORD_W +: COORD_W] = slotX[s];
      slotYVec[s*COORD_W +: COORD_W] = slotY[s];
    end
  end

  assign bus.slot_valid = slotValidVec;
  assign bus.slot_boom  = slotBoomVec;
  assign bus.slot_x     = slotXVec;
  assign bus.slot_y     = slotYVec;
  assign bus.q_bomb     = qBomb_q;
  assign bus.q_blast    = qBlast_q;
  assign bus.alive      = alive_q;
  assign bus.game_over  = gameOver_q;
  assign bus.winner     = winner_q;
  assign bus.draw       = draw_q;

endmodule

// File: tb/tb_bomb_arena_ctrl.sv
// Scenario bench for bomb_arena_ctrl; renderer queries are scored through an expectation queue.
module tb_bomb_arena_ctrl;

  logic clk;
  logic reset;
  int checks;
  int failures;

  typedef struct {
    int x;
    int y;
    bit expBomb;
    bit expBlast;
  } query_t;
  query_t expQ[$];

  bomb_arena_ctrl_if #(.N_PLAYERS(2), .BOMBS_PER_PLAYER(3), .COORD_W(6)) bus ();

  bomb_arena_ctrl #(
    .N_PLAYERS(2), .BOMBS_PER_PLAYER(3), .COORD_W(6), .FUSE_TICKS(120),
    .BLAST_TICKS(30), .BLAST_RANGE(2), .GRID_W(39), .GRID_H(29)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  // Reference coverage for range 2 on a 39x29 grid, written from relative offsets.
  function automatic bit tbCovered(int bx, int by, int tx, int ty);
    int dx, dy;
    dx = tx - bx;
    dy = ty - by;
    if (tx > 38 || ty > 28) return 1'b0;
    if (dx == 0 && dy == 0) return 1'b1;
    if (dy == 0 && (by % 2) == 1 && dx >= -2 && dx <= 2) return 1'b1;
    if (dx == 0 && (bx % 2) == 1 && dy >= -2 && dy <= 2) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setPlayer(int p, int x, int y);
    bus.pl_x[p*6 +: 6] = 6'(x);
    bus.pl_y[p*6 +: 6] = 6'(y);
  endtask

  task automatic dropBomb(int p);
    bus.drop[p] = 1'b1;
    cycle();
    bus.drop = '0;
  endtask

  task automatic doTicks(int n);
    repeat (n) begin
      bus.tick = 1'b1;
      cycle();
    end
    bus.tick = 1'b0;
  endtask

  task automatic restartRound();
    bus.restart = 1'b1;
    cycle();
    bus.restart = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.slot_valid, bus.slot_boom} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_slots: got %h expected 000", {bus.slot_valid, bus.slot_boom});
    end
    checks++;
    if ({bus.slot_x, bus.slot_y} !== 72'h0) begin
      failures++;
      $display("[TB] FAIL reset_coords: got %h expected 0", {bus.slot_x, bus.slot_y});
    end
    checks++;
    if ({bus.q_bomb, bus.q_blast} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_query: got %b expected 00", {bus.q_bomb, bus.q_blast});
    end
    checks++;
    if ({bus.alive, bus.game_over, bus.winner, bus.draw} !== 6'b110000) begin
      failures++;
      $display("[TB] FAIL reset_round: got %b expected 110000",
               {bus.alive, bus.game_over, bus.winner, bus.draw});
    end
  endtask

  task automatic test_basic_fuse();
    int qxs[12] = '{3, 3, 1, 2, 4, 5, 3, 3, 3, 0, 6, 2};
    int qys[12] = '{5, 6, 5, 5, 5, 5, 3, 7, 8, 5, 5, 4};
    query_t e;
    restartRound();
    setPlayer(0, 3, 5);
    setPlayer(1, 37, 27);
    dropBomb(0);
    setPlayer(0, 1, 1);
    checks++;
    if ({bus.slot_valid, bus.slot_x[5:0], bus.slot_y[5:0]} !== {6'b000001, 6'd3, 6'd5}) begin
      failures++;
      $display("[TB] FAIL fuse_alloc: got %h expected %h",
               {bus.slot_valid, bus.slot_x[5:0], bus.slot_y[5:0]}, {6'b000001, 6'd3, 6'd5});
    end
    for (int i = 0; i < 2; i++) begin
      bus.qx = 6'(qxs[i]);
      bus.qy = 6'(qys[i]);
      expQ.push_back('{qxs[i], qys[i], (i == 0), 1'b0});
      cycle();
      e = expQ.pop_front();
      checks++;
      if ({bus.q_bomb, bus.q_blast} !== {e.expBomb, e.expBlast}) begin
        failures++;
        $display("[TB] FAIL fuse_query_armed(%0d,%0d): got %b expected %b",
                 e.x, e.y, {bus.q_bomb, bus.q_blast}, {e.expBomb, e.expBlast});
      end
    end
    doTicks(119);
    checks++;
    if ({bus.slot_valid, bus.slot_boom} !== {6'b000001, 6'b000000}) begin
      failures++;
      $display("[TB] FAIL fuse_before_boom: got %b expected 000001000000",
               {bus.slot_valid, bus.slot_boom});
    end
    doTicks(1);
    checks++;
    if (bus.slot_boom !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL fuse_boom_at_120: got %b expected 000001", bus.slot_boom);
    end
    for (int i = 2; i < 12; i++) begin
      bus.qx = 6'(qxs[i]);
      bus.qy = 6'(qys[i]);
      expQ.push_back('{qxs[i], qys[i], 1'b0, tbCovered(3, 5, qxs[i], qys[i])});
      cycle();
      e = expQ.pop_front();
      checks++;
      if ({bus.q_bomb, bus.q_blast} !== {e.expBomb, e.expBlast}) begin
        failures++;
        $display("[TB] FAIL fuse_query_blast(%0d,%0d): got %b expected %b",
                 e.x, e.y, {bus.q_bomb, bus.q_blast}, {e.expBomb, e.expBlast});
      end
    end
    doTicks(29);
    checks++;
    if (bus.slot_boom !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL blast_before_free: got %b expected 000001", bus.slot_boom);
    end
    doTicks(1);
    checks++;
    if ({bus.slot_valid, bus.alive} !== {6'b000000, 2'b11}) begin
      failures++;
      $display("[TB] FAIL blast_free_at_30: got %b expected 00000011", {bus.slot_valid, bus.alive});
    end
  endtask

  task automatic test_capacity();
    query_t e;
    restartRound();
    setPlayer(0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      setPlayer(1, 7, 1 + 2 * i);
      dropBomb(1);
    end
    checks++;
    if (bus.slot_valid !== 6'b111000) begin
      failures++;
      $display("[TB] FAIL capacity_fill: got %b expected 111000", bus.slot_valid);
    end
    checks++;
    if ({bus.slot_y[18 +: 6], bus.slot_y[24 +: 6], bus.slot_y[30 +: 6]} !== {6'd1, 6'd3, 6'd5}) begin
      failures++;
      $display("[TB] FAIL capacity_order: got %h expected %h",
               {bus.slot_y[18 +: 6], bus.slot_y[24 +: 6], bus.slot_y[30 +: 6]}, {6'd1, 6'd3, 6'd5});
    end
    setPlayer(0, 7, 3);
    dropBomb(0);
    checks++;
    if (bus.slot_valid !== 6'b111000) begin
      failures++;
      $display("[TB] FAIL duplicate_tile: got %b expected 111000", bus.slot_valid);
    end
    restartRound();
    setPlayer(0, 9, 9);
    setPlayer(1, 9, 9);
    bus.drop = 2'b11;
    cycle();
    bus.drop = '0;
    checks++;
    if (bus.slot_valid !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL same_tile_priority: got %b expected 000001", bus.slot_valid);
    end
    bus.qx = 6'd9;
    bus.qy = 6'd9;
    expQ.push_back('{9, 9, 1'b1, 1'b0});
    cycle();
    e = expQ.pop_front();
    checks++;
    if ({bus.q_bomb, bus.q_blast} !== {e.expBomb, e.expBlast}) begin
      failures++;
      $display("[TB] FAIL capacity_query(%0d,%0d): got %b expected %b",
               e.x, e.y, {bus.q_bomb, bus.q_blast}, {e.expBomb, e.expBlast});
    end
  endtask

  task automatic test_wall_geometry();
    int qxs[16] = '{2, 6, 4, 7, 4, 4, 4, 0, 2, 3, 38, 37, 0, 0, 39, 63};
    int qys[16] = '{5, 5, 5, 5, 4, 6, 3, 1, 1, 1, 1, 1, 0, 2, 1, 5};
    query_t e;
    restartRound();
    setPlayer(0, 4, 5);
    setPlayer(1, 0, 1);
    bus.drop = 2'b11;
    cycle();
    bus.drop = '0;
    setPlayer(0, 37, 27);
    setPlayer(1, 35, 27);
    doTicks(120);
    checks++;
    if (bus.slot_boom !== 6'b001001) begin
      failures++;
      $display("[TB] FAIL wall_boom: got %b expected 001001", bus.slot_boom);
    end
    for (int i = 0; i < 16; i++) begin
      bus.qx = 6'(qxs[i]);
      bus.qy = 6'(qys[i]);
      expQ.push_back('{qxs[i], qys[i], 1'b0,
                       tbCovered(4, 5, qxs[i], qys[i]) | tbCovered(0, 1, qxs[i], qys[i])});
      cycle();
      e = expQ.pop_front();
      checks++;
      if ({bus.q_bomb, bus.q_blast} !== {e.expBomb, e.expBlast}) begin
        failures++;
        $display("[TB] FAIL wall_query(%0d,%0d): got %b expected %b",
                 e.x, e.y, {bus.q_bomb, bus.q_blast}, {e.expBomb, e.expBlast});
      end
    end
  endtask

  task automatic test_chain();
    restartRound();
    setPlayer(0, 3, 5);
    setPlayer(1, 37, 27);
    dropBomb(0);
    setPlayer(0, 1, 1);
    doTicks(50);
    setPlayer(1, 5, 5);
    dropBomb(1);
    setPlayer(1, 37, 27);
    doTicks(69);
    checks++;
    if (bus.slot_boom !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL chain_pre: got %b expected 000000", bus.slot_boom);
    end
    doTicks(1);
    checks++;
    if (bus.slot_boom !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL chain_first: got %b expected 000001", bus.slot_boom);
    end
    doTicks(1);
    checks++;
    if ({bus.slot_boom, bus.alive} !== {6'b001001, 2'b11}) begin
      failures++;
      $display("[TB] FAIL chain_second: got %b expected 00100111", {bus.slot_boom, bus.alive});
    end
  endtask

  task automatic test_win();
    restartRound();
    setPlayer(0, 3, 5);
    setPlayer(1, 37, 27);
    dropBomb(0);
    setPlayer(0, 1, 1);
    setPlayer(1, 3, 6);
    doTicks(120);
    checks++;
    if ({bus.game_over, bus.alive} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL win_pre: got %b expected 011", {bus.game_over, bus.alive});
    end
    doTicks(1);
    checks++;
    if ({bus.game_over, bus.draw, bus.winner, bus.alive} !== 6'b100001) begin
      failures++;
      $display("[TB] FAIL win_p0: got %b expected 100001",
               {bus.game_over, bus.draw, bus.winner, bus.alive});
    end
    doTicks(40);
    setPlayer(0, 9, 9);
    dropBomb(0);
    checks++;
    if ({bus.slot_valid, bus.slot_boom} !== {6'b000001, 6'b000001}) begin
      failures++;
      $display("[TB] FAIL over_freeze: got %b expected 000001000001", {bus.slot_valid, bus.slot_boom});
    end
    restartRound();
    setPlayer(1, 3, 5);
    setPlayer(0, 37, 27);
    dropBomb(1);
    setPlayer(1, 1, 1);
    setPlayer(0, 3, 4);
    doTicks(121);
    checks++;
    if ({bus.game_over, bus.draw, bus.winner, bus.alive} !== 6'b100110) begin
      failures++;
      $display("[TB] FAIL win_p1: got %b expected 100110",
               {bus.game_over, bus.draw, bus.winner, bus.alive});
    end
  endtask

  task automatic test_priority();
    setPlayer(0, 9, 9);
    bus.restart = 1'b1;
    bus.tick    = 1'b1;
    bus.drop    = 2'b01;
    cycle();
    bus.restart = 1'b0;
    bus.tick    = 1'b0;
    bus.drop    = '0;
    checks++;
    if ({bus.slot_valid, bus.game_over, bus.alive, bus.winner, bus.draw} !== 12'b000000011000) begin
      failures++;
      $display("[TB] FAIL restart_priority: got %b expected 000000011000",
               {bus.slot_valid, bus.game_over, bus.alive, bus.winner, bus.draw});
    end
    cycle();
    checks++;
    if (bus.slot_valid !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL restart_drop_dropped: got %b expected 000000", bus.slot_valid);
    end
  endtask

  task automatic test_draw();
    restartRound();
    setPlayer(0, 3, 5);
    setPlayer(1, 37, 27);
    dropBomb(0);
    setPlayer(0, 2, 5);
    setPlayer(1, 3, 4);
    doTicks(121);
    checks++;
    if ({bus.game_over, bus.draw, bus.alive} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL draw: got %b expected 1100", {bus.game_over, bus.draw, bus.alive});
    end
  endtask

  task automatic test_async_reset();
    restartRound();
    setPlayer(0, 3, 5);
    setPlayer(1, 37, 27);
    dropBomb(0);
    setPlayer(0, 1, 1);
    setPlayer(1, 3, 6);
    bus.qx = 6'd3;
    bus.qy = 6'd4;
    doTicks(121);
    checks++;
    if ({bus.slot_boom, bus.q_blast, bus.game_over, bus.alive} !== {6'b000001, 1'b1, 1'b1, 2'b01}) begin
      failures++;
      $display("[TB] FAIL pre_reset_state: got %b expected 0000011101",
               {bus.slot_boom, bus.q_blast, bus.game_over, bus.alive});
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.slot_valid, bus.slot_boom, bus.q_blast, bus.game_over, bus.alive} !== 15'b000000000000011) begin
      failures++;
      $display("[TB] FAIL async_reset_clear: got %b expected 000000000000011",
               {bus.slot_valid, bus.slot_boom, bus.q_blast, bus.game_over, bus.alive});
    end
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.tick    = 1'b0;
    bus.restart = 1'b0;
    bus.drop    = '0;
    bus.pl_x    = '0;
    bus.pl_y    = '0;
    bus.qx      = '0;
    bus.qy      = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();
    test_reset();
    test_basic_fuse();
    test_capacity();
    test_wall_geometry();
    test_chain();
    test_win();
    test_priority();
    test_draw();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bomb_arena_ctrl.md
Name: bomb_arena_ctrl

Overview:
Parametrised bomb and round controller for the tile arena; the successor to the fixed two-player, three-bomb put/crack/endflag logic.
- Owns a pool of N_PLAYERS*BOMBS_PER_PLAYER bomb slots with fuse timers, wall-aware cross blasts and chain detonation.
- Tracks per-player alive state and runs the round state machine (PLAY/OVER) with winner/draw reporting.
- Sits between the player-movement blocks and the pixel renderer; the renderer reads it through a registered tile query port.

Parameters:
N_PLAYERS, 2, number of players (2..4)
BOMBS_PER_PLAYER, 3, slots per player (1..8)
COORD_W, 6, tile coordinate width
FUSE_TICKS, 120, ticks from drop to explosion
BLAST_TICKS, 30, ticks a blast stays active
BLAST_RANGE, 2, arm length in tiles (1..7)
GRID_W, 39, arena width in tiles
GRID_H, 29, arena height in tiles

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle game-tick pulse (one per frame)
restart  in  1  one-cycle pulse; starts a new round
drop  in  N_PLAYERS  one-cycle drop request per player (already edge-detected)
pl_x  in  N_PLAYERS*COORD_W  packed player tile x; player p occupies bits [p*COORD_W +: COORD_W]
pl_y  in  N_PLAYERS*COORD_W  packed player tile y; same packing as pl_x
slot_valid  out  NS  slot occupied; NS = N_PLAYERS*BOMBS_PER_PLAYER
slot_boom  out  NS  slot is exploding
slot_x, slot_y  out  NS*COORD_W  packed slot coordinates
qx, qy  in  COORD_W  renderer tile query
q_bomb  out  1  an armed bomb is at (qx,qy); registered
q_blast  out  1  (qx,qy) lies inside an active blast; registered
alive  out  N_PLAYERS  player-alive mask
game_over  out  1  round is in OVER
winner  out  2  index of the surviving player; valid when game_over && !draw
draw  out  1  no player survived

Behaviour:
Reset values:
- All slot outputs 0; q_bomb=0, q_blast=0; alive=all ones; game_over=0; winner=0; draw=0; state=PLAY.
- Reset asserted mid-round clears everything immediately.

Slot ownership and states:
- Slot s belongs to player s/BOMBS_PER_PLAYER.
- Slot states: FREE, ARMED (fuse counter), BOOM (blast counter).

Drop (any cycle, PLAY only):
- drop[p] allocates the lowest-index FREE slot of player p at (pl_x[p], pl_y[p]).
- Allocated slot becomes ARMED with fuse=FUSE_TICKS.
- Drop is ignored if all of that player's slots are busy.
- Drop is ignored if any non-FREE slot already holds that tile.
- Same-cycle drops on the same tile: the lowest player index wins; the others are ignored.
- A drop coinciding with tick: allocation first; the new slot is not decremented that tick.

Blast geometry for a bomb at (bx,by):
- Centre tile is always covered.
- Horizontal arm covers x in [bx-R, bx+R] only if by is odd. Vertical arm covers y in [by-R, by+R] only if bx is odd. (Walls sit at even/even.)
- Arms are clipped to 0..GRID_W-1 and 0..GRID_H-1; no wrap-around.
- Use signed/widened compares; no underflow at coordinate 0.

On tick, in PLAY (all slots evaluated in parallel from the pre-tick state):
- ARMED with fuse==1, or its tile inside any BOOM blast → BOOM, blast counter=BLAST_TICKS. Otherwise fuse-1.
- Chain reactions therefore propagate one hop per tick.
- BOOM with counter==1 → FREE. Otherwise counter-1.
- alive[p] clears if player p's tile is inside any BOOM blast (pre-tick state).

Round state machine:
- PLAY→OVER on the tick after which popcount(alive)<=1.
- In OVER:
  - draw=1 if alive==0; otherwise winner=index of the single set bit.
  - Slots freeze; drop and tick are ignored.
- restart (either state) → all slots FREE, alive=all ones, draw=0, winner=0, state=PLAY, next cycle.
- restart has priority over same-cycle drop/tick.

Query port:
- q_bomb and q_blast reflect (qx,qy) against the current state, registered: one-cycle latency.
- Both read 0 for coordinates outside the grid.

Decomposition:
- Shared package bomb_pkg:
  - slot state enum (FREE/ARMED/BOOM);
  - the in-blast function (bx,by,tx,ty,range) → bool;
  - default grid constants GRID_W/GRID_H.
- Sub-module bomb_slot: one per slot via generate. It holds the state, coordinates and counter, and takes alloc/ignite/tick inputs.
- Allocation priority, chain OR-reduce, alive and round FSM stay in the top.

Test Plan:
- Basic fuse: P0 drops at (3,5) → slot0 ARMED; BOOM after exactly 120 ticks; FREE 30 ticks later; q_blast=1 at (1..5,5) and (3,3..7) during BOOM, 0 at (3,8).
- Capacity and duplicate: P1 drops 4 times on distinct tiles → only slots 3..5 fill. A P0 drop on a tile occupied by a P1 bomb is ignored.
- Wall geometry: bomb at (4,5) → horizontal arm present, vertical arm absent. Bomb at (0,1) → no coverage at negative x, no wrap to x=38.
- Chain reaction: bombs at (3,5) and (5,5) dropped 50 ticks apart → second enters BOOM one tick after the first explodes.
- Win and draw: P1 standing at (3,6) during a BOOM at (3,5) → alive=2'b01, game_over=1, winner=0. Both players in the blast on the same tick → draw=1.
- Priority: restart together with tick and drop in OVER → PLAY, all slots FREE, alive=11, drop ignored. Async reset mid-BOOM clears outputs immediately.
